// File: rtl/hp48_bus_ctrl.sv
// hp48_bus_ctrl
// Bus master sequencer for the HP48 nibble bus. It sits directly upstream of
// the daisy-chained bus devices (system RAM, I/O RAM, ROM).
// A CPU-side request for 1..MAX_NIB nibbles becomes:
//    - one LOAD_PC/LOAD_DP carrying the start address, then
//    - a burst of PC/DP READ or WRITE commands.
// The sequencer also issues single CONFIGURE and RESET commands for
// daisy-chain setup.
// All outputs come straight from flops. Each output's next value is computed
// from the next state, so what appears on the bus in a cycle always matches
// the state held in that cycle.

module hp48_bus_ctrl #(
   parameter  int ADDR_W  = 20,
   parameter  int MAX_NIB = 16,
   localparam int LEN_W   = (MAX_NIB > 1) ? $clog2(MAX_NIB) : 1,
   localparam int DATA_W  = 4 * MAX_NIB
) (
   input  logic              strobe,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_use_pc,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              error,
   input  logic              cfg_valid,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic              bus_reset_req,
   output logic [ADDR_W-1:0] bus_address,
   output logic [3:0]        bus_command,
   output logic [3:0]        bus_nibble_out,
   input  logic [3:0]        bus_nibble_in,
   input  logic              bus_active
);

   // Bus command codes (same values as the BUSCMD_* macros of the bus devices)
   localparam logic [3:0] BUSCMD_NOP       = 4'h0;
   localparam logic [3:0] BUSCMD_PC_READ   = 4'h1;
   localparam logic [3:0] BUSCMD_DP_READ   = 4'h2;
   localparam logic [3:0] BUSCMD_PC_WRITE  = 4'h3;
   localparam logic [3:0] BUSCMD_DP_WRITE  = 4'h4;
   localparam logic [3:0] BUSCMD_LOAD_PC   = 4'h5;
   localparam logic [3:0] BUSCMD_LOAD_DP   = 4'h6;
   localparam logic [3:0] BUSCMD_CONFIGURE = 4'h7;
   localparam logic [3:0] BUSCMD_RESET     = 4'hF;

   localparam logic [LEN_W-1:0] IDX_ONE = LEN_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_XFER  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FIN   = 3'd4,
      ST_CFG   = 3'd5,
      ST_RST   = 3'd6
   } state_t;

   state_t state_q, state_d;

   // Latched request
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              write_q, write_d;
   logic              use_pc_q, use_pc_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   // Burst progress and read pipeline
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic              cap_pend_q, cap_pend_d;
   logic [LEN_W-1:0]  cap_idx_q, cap_idx_d;

   // Registered outputs
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              ready_q, ready_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] baddr_q, baddr_d;
   logic [3:0]        nib_out_q, nib_out_d;

   logic accept_s;
   logic last_s;

   // A request is taken only from IDLE and only when no RESET/CONFIGURE is pending
   assign accept_s = (state_q == ST_IDLE) && !bus_reset_req && !cfg_valid && req_valid;
   // Current XFER cycle carries the final nibble of the burst
   assign last_s   = (idx_q == len_q);

   // State register
   always_ff @(posedge strobe) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: RESET beats CONFIGURE beats a transfer; a missing responder ends the burst early
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus_reset_req) begin
               state_d = ST_RST;
            end else if (cfg_valid) begin
               state_d = ST_CFG;
            end else if (accept_s) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RST:   state_d = ST_IDLE;
         ST_CFG:   state_d = ST_IDLE;
         ST_LOAD:  state_d = ST_XFER;
         ST_XFER: begin
            if (!bus_active || last_s) begin
               state_d = write_q ? ST_FIN : ST_DRAIN;
            end else begin
               state_d = ST_XFER;
            end
         end
         ST_DRAIN: state_d = ST_FIN;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Request latch, nibble index, sticky error and read-data capture
   always_comb begin
      addr_d     = addr_q;
      len_d      = len_q;
      write_d    = write_q;
      use_pc_d   = use_pc_q;
      wdata_d    = wdata_q;
      idx_d      = idx_q;
      error_d    = error_q;
      rd_data_d  = rd_data_q;
      cap_pend_d = 1'b0;
      cap_idx_d  = idx_q;

      if (accept_s) begin
         addr_d    = req_addr;
         len_d     = req_len;
         write_d   = req_write;
         use_pc_d  = req_use_pc;
         wdata_d   = wr_data;
         idx_d     = '0;
         error_d   = 1'b0;
         rd_data_d = '0;
      end else if (state_q == ST_XFER) begin
         if (!bus_active) begin
            // Nobody answered: flag it and do not expect a nibble for this cycle
            error_d = 1'b1;
         end else begin
            // The device registers its nibble now; it is captured one edge later
            cap_pend_d = !write_q;
            if (!last_s) begin
               idx_d = idx_q + IDX_ONE;
            end else begin
               idx_d = idx_q;
            end
         end
      end else begin
         idx_d = idx_q;
      end

      // Read nibble issued in the previous cycle is on bus_nibble_in now
      if (cap_pend_q) begin
         rd_data_d[{cap_idx_q, 2'b00} +: 4] = bus_nibble_in;
      end else begin
         rd_data_d = rd_data_d;
      end
   end

   // Bus-side outputs derived from the state being entered
   always_comb begin
      cmd_d     = BUSCMD_NOP;
      baddr_d   = '0;
      nib_out_d = 4'h0;
      done_d    = (state_d == ST_FIN);
      ready_d   = (state_d == ST_IDLE);
      case (state_d)
         ST_RST: begin
            cmd_d   = BUSCMD_RESET;
            baddr_d = '0;
         end
         ST_CFG: begin
            cmd_d   = BUSCMD_CONFIGURE;
            baddr_d = cfg_addr;
         end
         ST_LOAD: begin
            cmd_d   = use_pc_d ? BUSCMD_LOAD_PC : BUSCMD_LOAD_DP;
            baddr_d = addr_d;
         end
         ST_XFER: begin
            baddr_d = addr_d;
            if (write_d) begin
               cmd_d     = use_pc_d ? BUSCMD_PC_WRITE : BUSCMD_DP_WRITE;
               nib_out_d = wdata_d[{idx_d, 2'b00} +: 4];
            end else begin
               cmd_d     = use_pc_d ? BUSCMD_PC_READ : BUSCMD_DP_READ;
               nib_out_d = 4'h0;
            end
         end
         default: begin
            cmd_d     = BUSCMD_NOP;
            baddr_d   = '0;
            nib_out_d = 4'h0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge strobe) begin
      if (reset) begin
         addr_q     <= '0;
         len_q      <= '0;
         write_q    <= 1'b0;
         use_pc_q   <= 1'b0;
         wdata_q    <= '0;
         idx_q      <= '0;
         cap_pend_q <= 1'b0;
         cap_idx_q  <= '0;
         rd_data_q  <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         ready_q    <= 1'b1;
         cmd_q      <= BUSCMD_NOP;
         baddr_q    <= '0;
         nib_out_q  <= 4'h0;
      end else begin
         addr_q     <= addr_d;
         len_q      <= len_d;
         write_q    <= write_d;
         use_pc_q   <= use_pc_d;
         wdata_q    <= wdata_d;
         idx_q      <= idx_d;
         cap_pend_q <= cap_pend_d;
         cap_idx_q  <= cap_idx_d;
         rd_data_q  <= rd_data_d;
         done_q     <= done_d;
         error_q    <= error_d;
         ready_q    <= ready_d;
         cmd_q      <= cmd_d;
         baddr_q    <= baddr_d;
         nib_out_q  <= nib_out_d;
      end
   end

   assign req_ready      = ready_q;
   assign rd_data        = rd_data_q;
   assign done           = done_q;
   assign error          = error_q;
   assign bus_command    = cmd_q;
   assign bus_address    = baddr_q;
   assign bus_nibble_out = nib_out_q;

endmodule

// File: tb/tb_hp48_bus_ctrl.sv
// tb_hp48_bus_ctrl
// Self-checking bench for hp48_bus_ctrl. A device model answers read commands
// from a response word and drops bus_active on a chosen XFER cycle. Per-cycle
// expectations come from the burst shape: LOAD, k transfers, an optional drain,
// then FIN. A directed table, random requests and hand-written sequences
// (priority, mid-burst reset) exercise the design.

module tb_hp48_bus_ctrl;

   localparam logic [3:0] C_NOP   = 4'h0;
   localparam logic [3:0] C_PC_RD = 4'h1;
   localparam logic [3:0] C_DP_RD = 4'h2;
   localparam logic [3:0] C_PC_WR = 4'h3;
   localparam logic [3:0] C_DP_WR = 4'h4;
   localparam logic [3:0] C_LD_PC = 4'h5;
   localparam logic [3:0] C_LD_DP = 4'h6;
   localparam logic [3:0] C_CFG   = 4'h7;
   localparam logic [3:0] C_RST   = 4'hF;

   logic        strobe;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_use_pc;
   logic [19:0] req_addr;
   logic [3:0]  req_len;
   logic [63:0] wr_data;
   logic [63:0] rd_data;
   logic        done;
   logic        error;
   logic        cfg_valid;
   logic [19:0] cfg_addr;
   logic        bus_reset_req;
   logic [19:0] bus_address;
   logic [3:0]  bus_command;
   logic [3:0]  bus_nibble_out;
   logic [3:0]  bus_nibble_in;
   logic        bus_active;

   int total = 0;
   int bad   = 0;

   // Device model state
   logic [63:0] resp_g;
   int          drop_g;
   int          xfer_cnt;
   bit          prev_rd;
   int          prev_idx;

   hp48_bus_ctrl dut (
      .strobe         (strobe),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_use_pc     (req_use_pc),
      .req_addr       (req_addr),
      .req_len        (req_len),
      .wr_data        (wr_data),
      .rd_data        (rd_data),
      .done           (done),
      .error          (error),
      .cfg_valid      (cfg_valid),
      .cfg_addr       (cfg_addr),
      .bus_reset_req  (bus_reset_req),
      .bus_address    (bus_address),
      .bus_command    (bus_command),
      .bus_nibble_out (bus_nibble_out),
      .bus_nibble_in  (bus_nibble_in),
      .bus_active     (bus_active)
   );

   initial strobe = 1'b0;
   always #5 strobe = ~strobe;

   task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s: got %0h want %0h", tag, what, act, exp);
      end
   endtask

   // Advance to the next negedge and play the device side for the cycle now visible
   task automatic tick();
      bit is_r;
      bit is_x;
      @(negedge strobe);
      if (prev_rd) bus_nibble_in = resp_g[prev_idx*4 +: 4];
      else         bus_nibble_in = 4'h0;
      is_r = (bus_command == C_PC_RD) || (bus_command == C_DP_RD);
      is_x = is_r || (bus_command == C_PC_WR) || (bus_command == C_DP_WR);
      if (is_x) begin
         xfer_cnt++;
         bus_active = (xfer_cnt != drop_g);
         prev_rd    = is_r && bus_active;
         prev_idx   = xfer_cnt - 1;
      end else begin
         bus_active = 1'b0;
         prev_rd    = 1'b0;
      end
   endtask

   // Issue one request (DUT must be IDLE) and check every cycle up to one past done
   task automatic run_txn(input bit wr, input bit pc, input logic [19:0] addr, input logic [3:0] len,
                          input logic [63:0] wdata, input logic [63:0] resp, input int drop,
                          input int exp_done, input logic [63:0] exp_rd, input bit exp_err,
                          input string tag);
      int n;
      int k;
      int nx;
      logic [3:0] xcmd;
      logic [3:0] ecmd;
      bit chk_a;
      n  = int'(len) + 1;
      k  = (drop != 0) ? drop : n;
      nx = 0;
      if (wr) xcmd = pc ? C_PC_WR : C_DP_WR;
      else    xcmd = pc ? C_PC_RD : C_DP_RD;
      req_write  = wr;
      req_use_pc = pc;
      req_addr   = addr;
      req_len    = len;
      wr_data    = wdata;
      req_valid  = 1'b1;
      resp_g     = resp;
      drop_g     = drop;
      xfer_cnt   = 0;
      prev_rd    = 1'b0;
      for (int c = 1; c <= exp_done + 1; c++) begin
         tick();
         if (c == 1) req_valid = 1'b0;
         if (c == 1) begin
            ecmd  = pc ? C_LD_PC : C_LD_DP;
            chk_a = 1'b1;
         end else if (c <= k + 1) begin
            ecmd  = xcmd;
            chk_a = 1'b1;
         end else begin
            ecmd  = C_NOP;
            chk_a = 1'b0;
         end
         chk(tag, $sformatf("cmd@%0d", c), 64'(bus_command), 64'(ecmd));
         if (chk_a) chk(tag, $sformatf("addr@%0d", c), 64'(bus_address), 64'(addr));
         if (wr && c >= 2 && c <= k + 1)
            chk(tag, $sformatf("nib@%0d", c), 64'(bus_nibble_out), 64'(wdata[(c-2)*4 +: 4]));
         chk(tag, $sformatf("done@%0d", c), 64'(done), 64'(c == exp_done));
         chk(tag, $sformatf("ready@%0d", c), 64'(req_ready), 64'(c == exp_done + 1));
         chk(tag, $sformatf("error@%0d", c), 64'(error), 64'(exp_err && (c >= drop + 2)));
         if (c == 1) chk(tag, "rd_clr", rd_data, 64'h0);
         if (bus_command == xcmd) nx++;
      end
      chk(tag, "xfers", 64'(nx), 64'(k));
      chk(tag, "rd_data", rd_data, exp_rd);
   endtask

   typedef struct {
      bit          wr;
      bit          pc;
      logic [19:0] addr;
      logic [3:0]  len;
      logic [63:0] wdata;
      logic [63:0] resp;
      int          drop;
      int          exp_done;
      logic [63:0] exp_rd;
      bit          exp_err;
   } vec_t;

   vec_t vecs[10];

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_use_pc = 1'b0;
      req_addr = 20'h0; req_len = 4'h0; wr_data = 64'h0;
      cfg_valid = 1'b0; cfg_addr = 20'h0; bus_reset_req = 1'b0;
      bus_nibble_in = 4'h0; bus_active = 1'b0;
      resp_g = 64'h0; drop_g = 0; xfer_cnt = 0; prev_rd = 1'b0; prev_idx = 0;

      //        wr    pc    addr        len   wdata                   resp                    drop done rd                      err
      vecs[0] = '{1'b1, 1'b0, 20'h80000, 4'd3,  64'hDCBA,               64'h0,                  0, 6,  64'h0,                  1'b0};
      vecs[1] = '{1'b0, 1'b1, 20'h80010, 4'd1,  64'h0,                  64'h95,                 0, 5,  64'h95,                 1'b0};
      vecs[2] = '{1'b0, 1'b1, 20'h12345, 4'd15, 64'h0,                  64'hFEDCBA9876543210,   0, 19, 64'hFEDCBA9876543210,   1'b0};
      vecs[3] = '{1'b0, 1'b0, 20'h40000, 4'd3,  64'h0,                  64'h4321,               2, 5,  64'h1,                  1'b1};
      vecs[4] = '{1'b1, 1'b1, 20'h00001, 4'd0,  64'h7,                  64'h0,                  0, 3,  64'h0,                  1'b0};
      vecs[5] = '{1'b1, 1'b0, 20'hFFFFF, 4'd15, 64'h0123456789ABCDEF,   64'h0,                  0, 18, 64'h0,                  1'b0};
      vecs[6] = '{1'b0, 1'b0, 20'h00002, 4'd0,  64'h0,                  64'hA,                  0, 4,  64'hA,                  1'b0};
      vecs[7] = '{1'b0, 1'b1, 20'h5A5A5, 4'd7,  64'h0,                  64'h87654321,           1, 4,  64'h0,                  1'b1};
      vecs[8] = '{1'b1, 1'b0, 20'h33333, 4'd5,  64'h654321,             64'h0,                  3, 5,  64'h0,                  1'b1};
      vecs[9] = '{1'b0, 1'b0, 20'h00100, 4'd2,  64'h0,                  64'hCBA,                3, 6,  64'hBA,                 1'b1};

      // Reset state
      repeat (3) tick();
      chk("reset", "cmd",   64'(bus_command),    64'(C_NOP));
      chk("reset", "addr",  64'(bus_address),    64'h0);
      chk("reset", "nib",   64'(bus_nibble_out), 64'h0);
      chk("reset", "rd",    rd_data,             64'h0);
      chk("reset", "done",  64'(done),           64'h0);
      chk("reset", "error", 64'(error),          64'h0);
      chk("reset", "ready", 64'(req_ready),      64'h1);
      reset = 1'b0;
      tick();
      chk("idle", "ready", 64'(req_ready), 64'h1);

      // Directed table
      for (int v = 0; v < 10; v++) begin
         run_txn(vecs[v].wr, vecs[v].pc, vecs[v].addr, vecs[v].len, vecs[v].wdata, vecs[v].resp,
                 vecs[v].drop, vecs[v].exp_done, vecs[v].exp_rd, vecs[v].exp_err, $sformatf("vec%0d", v));
      end

      // Random requests against the burst model
      for (int r = 0; r < 12; r++) begin
         bit          wr;
         bit          pc;
         logic [19:0] addr;
         logic [3:0]  len;
         logic [63:0] wdata;
         logic [63:0] resp;
         logic [63:0] erd;
         int          n;
         int          drop;
         int          ncap;
         int          dcyc;
         wr    = 1'($urandom_range(0, 1));
         pc    = 1'($urandom_range(0, 1));
         addr  = 20'($urandom);
         len   = 4'($urandom_range(0, 15));
         wdata = {$urandom, $urandom};
         resp  = {$urandom, $urandom};
         n     = int'(len) + 1;
         drop  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0;
         dcyc  = ((drop != 0) ? drop : n) + 2 + (wr ? 0 : 1);
         ncap  = (drop != 0) ? drop - 1 : n;
         erd   = 64'h0;
         if (!wr) for (int j = 0; j < ncap; j++) erd[j*4 +: 4] = resp[j*4 +: 4];
         run_txn(wr, pc, addr, len, wdata, resp, drop, dcyc, erd, drop != 0, $sformatf("rnd%0d", r));
      end

      // RESET, CONFIGURE and a transfer all requested together
      bus_reset_req = 1'b1; cfg_valid = 1'b1; cfg_addr = 20'hC0000;
      req_write = 1'b1; req_use_pc = 1'b0; req_addr = 20'h01234; req_len = 4'd1;
      wr_data = 64'h5E; req_valid = 1'b1; drop_g = 0; xfer_cnt = 0;
      tick();
      chk("prio", "rst_cmd",  64'(bus_command), 64'(C_RST));
      chk("prio", "rst_addr", 64'(bus_address), 64'h0);
      chk("prio", "rst_done", 64'(done),        64'h0);
      bus_reset_req = 1'b0;
      tick();
      chk("prio", "idle1_cmd",   64'(bus_command), 64'(C_NOP));
      chk("prio", "idle1_ready", 64'(req_ready),   64'h1);
      tick();
      chk("prio", "cfg_cmd",  64'(bus_command), 64'(C_CFG));
      chk("prio", "cfg_addr", 64'(bus_address), 64'hC0000);
      chk("prio", "cfg_done", 64'(done),        64'h0);
      cfg_valid = 1'b0;
      tick();
      chk("prio", "idle2_ready", 64'(req_ready), 64'h1);
      run_txn(1'b1, 1'b0, 20'h01234, 4'd1, 64'h5E, 64'h0, 0, 4, 64'h0, 1'b0, "prio_xfer");

      // Reset during the second XFER cycle of a write
      req_write = 1'b1; req_use_pc = 1'b0; req_addr = 20'h22222; req_len = 4'd3;
      wr_data = 64'h9876; req_valid = 1'b1; drop_g = 0; xfer_cnt = 0;
      tick();
      chk("mrst", "load", 64'(bus_command), 64'(C_LD_DP));
      req_valid = 1'b0;
      tick();
      chk("mrst", "x0", 64'(bus_command), 64'(C_DP_WR));
      tick();
      chk("mrst", "x1",     64'(bus_command),    64'(C_DP_WR));
      chk("mrst", "x1_nib", 64'(bus_nibble_out), 64'h7);
      reset = 1'b1;
      tick();
      chk("mrst", "cmd",   64'(bus_command), 64'(C_NOP));
      chk("mrst", "ready", 64'(req_ready),   64'h1);
      chk("mrst", "done",  64'(done),        64'h0);
      chk("mrst", "addr",  64'(bus_address), 64'h0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mrst", $sformatf("post_done%0d", i), 64'(done),        64'h0);
         chk("mrst", $sformatf("post_cmd%0d", i),  64'(bus_command), 64'(C_NOP));
      end
      run_txn(1'b0, 1'b1, 20'h0ABCD, 4'd2, 64'h0, 64'h3C1, 0, 6, 64'h3C1, 1'b0, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
